snake_dir_ctrl: RTL and testbench
=================================

Name: snake_dir_ctrl

Overview:
Sits directly downstream of the PS/2 keyboard decoder. It moves the decoder's one-hot direction code (produced in the kb_clock domain) into the system clock domain and rejects illegal turns. Accepted turns are buffered in a small queue and released one per game tick, giving the snake movement engine a stable, legal heading.

Parameters:
QUEUE_DEPTH, 2, number of pending turns held (2..4)
SYNC_STAGES, 2, synchronizer flops per input bit (>=2)
INIT_DIR, 4'b1000, heading after reset (RIGHT)

Ports:
clock  input  1  system clock (50 MHz)
reset  input  1  synchronous, active-high
mapped_key  input  8  decoder output, asynchronous to clock; only [3:0] used (0001 UP, 0010 DOWN, 0100 LEFT, 1000 RIGHT)
enable  input  1  game running; low = paused or game over
game_tick  input  1  one-cycle pulse per snake step
direction  output  4  current one-hot heading
dir_changed  output  1  one-cycle pulse when direction updates
queue_count  output  3  pending turns, 0..QUEUE_DEPTH
rejected  output  1  one-cycle pulse: turn was same or opposite of reference heading
dropped  output  1  one-cycle pulse: legal turn lost because queue was full

Behaviour:
- Reset:
  - direction = INIT_DIR; queue empty; queue_count = 0.
  - dir_changed, rejected, dropped = 0.
  - Sync flops, stable register and last-value register = 0.
- Input path:
  - mapped_key[3:0] passes through SYNC_STAGES flops per bit. Bits [7:4] are ignored.
  - Stability filter: the stable value loads the synced value only when that value equals the previous cycle's synced value. Otherwise the stable value holds. This removes multi-bit skew.
- Event detection:
  - An event fires on the cycle the stable value changes to a value that is exactly one-hot and differs from the previous stable value.
  - Changes to 0 or to non-one-hot values update the last value but raise no event.
  - Re-pressing the same key (key -> 0 on break -> key) yields a new event.
- Event latency: with setup met, a mapped_key change is visible in queue_count or rejected/dropped on the (SYNC_STAGES+2)th rising edge.
- Reference heading = queue tail if queue_count > 0, else direction.
- Event classification:
  - Equal to the reference or opposite it (UP/DOWN, LEFT/RIGHT): not queued; rejected pulses.
  - Legal and queue not full: pushed.
  - Legal and queue full with no pop this cycle: discarded; dropped pulses.
- Pop: on a game_tick with enable = 1 and queue non-empty, the head is removed. direction takes that value on the same edge, and dir_changed pulses in the following cycle (registered).
- Tick with an empty queue: direction holds; no pulse.
- Simultaneous push and pop:
  - Both occur; queue_count is unchanged.
  - The reference heading is evaluated from pre-edge state.
  - A full queue with a simultaneous pop accepts the push (no drop).
  - An empty queue with a simultaneous tick pushes only; there is no bypass to direction.
- enable = 0:
  - Queue cleared synchronously; game_tick ignored; events discarded silently (no rejected/dropped).
  - direction holds. The sync and filter registers keep running.
- Queue is circular with head/tail pointers of clog2(QUEUE_DEPTH) bits, wrapping at QUEUE_DEPTH-1. Full/empty is resolved by queue_count.
- The output pulses are mutually exclusive per event; dir_changed is independent of them.
- A reset mid-operation (including mid-synchronization) returns every state to its reset values on the next edge.

Decomposition:
- Shared package snake_pkg:
  - Direction localparams DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT, DIR_NONE.
  - Function opposite_dir(dir).
  - Function is_onehot4(v).
- Sub-module key_sync: per-bit SYNC_STAGES synchronizer plus stability filter. It outputs the stable 4-bit value and a one-cycle new_key pulse. It is instantiated once.
- Queue, classification and direction register live in snake_dir_ctrl.

Test Plan:
- Reset release, no input, 5 game_ticks -> direction = 1000, dir_changed never pulses, queue_count = 0.
- enable = 1, mapped_key 00 -> 01 (UP), then one tick -> queue_count = 1 after SYNC_STAGES+2 edges; after the tick, direction = 0001 and dir_changed pulses one cycle later; queue_count = 0.
- Heading RIGHT, key LEFT (0100) -> rejected pulses once, queue_count stays 0. Then key DOWN (0010), then key UP (0001) -> DOWN queued; UP rejected against tail DOWN.
- QUEUE_DEPTH = 2, heading RIGHT, keys UP, LEFT, DOWN with no ticks -> queue_count = 2, dropped pulses on DOWN. Three ticks -> direction sequence UP, LEFT, then holds LEFT.
- Full queue, legal event on the same edge as game_tick -> no drop, queue_count stays 2, head popped to direction.
- Two queued turns, enable dropped to 0 for 1 cycle, then tick with enable = 1 -> queue_count = 0, direction unchanged, no dir_changed. Separately, reset asserted with 2 queued -> direction = 1000, all outputs 0.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg: shared direction encodings and helper functions for the snake
// direction controller.
//   DIR_*         one-hot headings as produced by the keyboard decoder
//   opposite_dir  returns the heading 180 degrees from the argument
//   is_onehot4    true when exactly one of four bits is set
package snake_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  // Reverse of a one-hot heading; anything else maps to DIR_NONE so it can
  // never match a real heading.
  function automatic logic [3:0] opposite_dir(input logic [3:0] dir);
    logic [3:0] res;
    case (dir)
      DIR_UP:    res = DIR_DOWN;
      DIR_DOWN:  res = DIR_UP;
      DIR_LEFT:  res = DIR_RIGHT;
      DIR_RIGHT: res = DIR_LEFT;
      default:   res = DIR_NONE;
    endcase
    return res;
  endfunction

  // Clearing the lowest set bit leaves zero only for a single-bit value.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/key_sync.sv
// key_sync: brings the decoder's 4-bit direction code into the system clock
// domain and filters out multi-bit skew.
//   clock, reset  system clock, synchronous active-high reset
//   key_in        asynchronous direction code (4 bits)
//   key_next      value the stable register holds after this edge
//   new_key       high in the cycle the stable value changes to a new one-hot
//                 code; qualifies key_next and is consumed on the same edge
module key_sync
  import snake_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_in,
  output logic [3:0] key_next,
  output logic       new_key
);

  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sync_d [SYNC_STAGES];
  logic [3:0] last_q;
  logic [3:0] last_d;
  logic [3:0] stable_q;
  logic [3:0] stable_d;
  logic       load_s;
  logic [3:0] synced_s;

  // Synchronizer shift, skew filter and change detection.
  always_comb begin
    sync_d[0] = key_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    synced_s = sync_q[SYNC_STAGES-1];
    last_d   = synced_s;
    // Only a value seen on two consecutive cycles is trusted; during skew
    // the bits disagree between cycles and the stable value holds.
    load_s   = (synced_s == last_q);
    if (load_s) begin
      stable_d = synced_s;
    end else begin
      stable_d = stable_q;
    end
    new_key  = load_s && is_onehot4(synced_s) && (synced_s != stable_q);
    key_next = stable_d;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 4'b0000;
      end
      last_q   <= 4'b0000;
      stable_q <= 4'b0000;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      last_q   <= last_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: turns keyboard direction codes into a legal snake heading.
// Turns equal or opposite to the reference heading are rejected, legal ones
// are queued and released one per game tick.
//   clock, reset  system clock, synchronous active-high reset
//   mapped_key    decoder output (async), only [3:0] used
//   enable        game running; low clears the queue and freezes the heading
//   game_tick     one-cycle pulse per snake step
//   direction     current one-hot heading
//   dir_changed   pulse in the cycle after direction was loaded
//   queue_count   number of pending turns
//   rejected      pulse: turn equal/opposite to reference heading
//   dropped       pulse: legal turn lost to a full queue
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int         QUEUE_DEPTH = 2,
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] INIT_DIR    = 4'b1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] mapped_key,
  input  logic       enable,
  input  logic       game_tick,
  output logic [3:0] direction,
  output logic       dir_changed,
  output logic [2:0] queue_count,
  output logic       rejected,
  output logic       dropped
);

  localparam int               PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [2:0]       CNT_MAX  = 3'(QUEUE_DEPTH);

  // Circular increment wrapping at QUEUE_DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return PTR_ZERO;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  logic [3:0]       mem_q [QUEUE_DEPTH];
  logic [3:0]       mem_d [QUEUE_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0]       count_q, count_d;
  logic [3:0]       direction_q, direction_d;
  logic             dir_changed_q, dir_changed_d;
  logic             rejected_q, rejected_d;
  logic             dropped_q, dropped_d;

  logic [3:0]       key_s;
  logic             new_key_s;
  logic [PTR_W-1:0] tail_idx_s;
  logic [3:0]       ref_dir_s;
  logic             illegal_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             unused_key_hi_s;

  assign unused_key_hi_s = ^mapped_key[7:4];

  key_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_key_sync (
    .clock   (clock),
    .reset   (reset),
    .key_in  (mapped_key[3:0]),
    .key_next(key_s),
    .new_key (new_key_s)
  );

  // Classification, queue push/pop and heading update.
  always_comb begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    direction_d   = direction_q;
    dir_changed_d = 1'b0;
    rejected_d    = 1'b0;
    dropped_d     = 1'b0;

    // wr_ptr points at the next free slot, so the newest entry is one behind.
    if (wr_ptr_q == PTR_ZERO) begin
      tail_idx_s = PTR_LAST;
    end else begin
      tail_idx_s = wr_ptr_q - PTR_W'(1);
    end
    if (count_q != 3'd0) begin
      ref_dir_s = mem_q[tail_idx_s];
    end else begin
      ref_dir_s = direction_q;
    end
    illegal_s = (key_s == ref_dir_s) || (key_s == opposite_dir(ref_dir_s));
    full_s    = (count_q == CNT_MAX);
    pop_s     = enable && game_tick && (count_q != 3'd0);
    // A pop on the same edge frees the slot the push needs.
    push_s    = enable && new_key_s && !illegal_s && (!full_s || pop_s);

    if (!enable) begin
      rd_ptr_d = PTR_ZERO;
      wr_ptr_d = PTR_ZERO;
      count_d  = 3'd0;
    end else begin
      if (pop_s) begin
        direction_d   = mem_q[rd_ptr_q];
        rd_ptr_d      = ptr_inc(rd_ptr_q);
        dir_changed_d = 1'b1;
      end else begin
        direction_d = direction_q;
      end
      // When full with a pop, this writes the head slot that is being read
      // out on the same edge; the read uses the pre-edge contents.
      if (push_s) begin
        mem_d[wr_ptr_q] = key_s;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (new_key_s && illegal_s) begin
        rejected_d = 1'b1;
      end else if (new_key_s && !push_s) begin
        dropped_d = 1'b1;
      end else begin
        rejected_d = 1'b0;
        dropped_d  = 1'b0;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem_q[i] <= 4'b0000;
      end
      rd_ptr_q      <= PTR_ZERO;
      wr_ptr_q      <= PTR_ZERO;
      count_q       <= 3'd0;
      direction_q   <= INIT_DIR;
      dir_changed_q <= 1'b0;
      rejected_q    <= 1'b0;
      dropped_q     <= 1'b0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      direction_q   <= direction_d;
      dir_changed_q <= dir_changed_d;
      rejected_q    <= rejected_d;
      dropped_q     <= dropped_d;
    end
  end

  assign direction   = direction_q;
  assign dir_changed = dir_changed_q;
  assign queue_count = count_q;
  assign rejected    = rejected_q;
  assign dropped     = dropped_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb_snake_dir_ctrl: directed and random stimulus for snake_dir_ctrl, checked
// every cycle against a behavioural model built on a queue of pending turns.
module tb_snake_dir_ctrl;

  localparam int QD = 2;
  localparam int SS = 2;

  logic       clock;
  logic       reset;
  logic [7:0] mapped_key;
  logic       enable;
  logic       game_tick;
  logic [3:0] direction;
  logic       dir_changed;
  logic [2:0] queue_count;
  logic       rejected;
  logic       dropped;

  int checks;
  int errors;

  // Reference model state.
  logic [3:0] m_dir;
  logic [3:0] m_q[$];
  logic [3:0] m_stable;
  logic [3:0] hist[$];
  logic       m_dc;
  logic       m_rej;
  logic       m_drop;

  snake_dir_ctrl #(
    .QUEUE_DEPTH(QD),
    .SYNC_STAGES(SS),
    .INIT_DIR   (4'b1000)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mapped_key (mapped_key),
    .enable     (enable),
    .game_tick  (game_tick),
    .direction  (direction),
    .dir_changed(dir_changed),
    .queue_count(queue_count),
    .rejected   (rejected),
    .dropped    (dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [3:0] opp(input logic [3:0] d);
    case (d)
      4'b0001: return 4'b0010;
      4'b0010: return 4'b0001;
      4'b0100: return 4'b1000;
      4'b1000: return 4'b0100;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic model_reset();
    m_dir    = 4'b1000;
    m_q.delete();
    m_stable = 4'b0000;
    hist.delete();
    for (int i = 0; i < SS + 2; i++) hist.push_back(4'b0000);
    m_dc   = 1'b0;
    m_rej  = 1'b0;
    m_drop = 1'b0;
  endtask

  // One rising edge of the reference behaviour.
  // hist[j] is the key present j edges ago; a key is accepted SS edges after
  // it was sampled, provided it was also there one edge earlier.
  task automatic model_edge(input logic [7:0] key, input logic en, input logic tick,
                            input logic rst);
    logic       ev;
    logic       pop;
    logic       push;
    logic [3:0] refd;
    logic [3:0] k;
    if (rst) begin
      model_reset();
      return;
    end
    hist.push_front(key[3:0]);
    void'(hist.pop_back());
    ev = 1'b0;
    if (hist[SS] == hist[SS+1] && hist[SS] != m_stable) begin
      m_stable = hist[SS];
      ev       = ($countones(m_stable) == 1);
    end
    k      = m_stable;
    m_dc   = 1'b0;
    m_rej  = 1'b0;
    m_drop = 1'b0;
    if (!en) begin
      m_q.delete();
    end else begin
      refd = (m_q.size() > 0) ? m_q[$] : m_dir;
      pop  = tick && (m_q.size() > 0);
      push = 1'b0;
      if (ev) begin
        if (k == refd || k == opp(refd)) m_rej = 1'b1;
        else if (m_q.size() < QD || pop) push = 1'b1;
        else m_drop = 1'b1;
      end
      if (pop) begin
        m_dir = m_q.pop_front();
        m_dc  = 1'b1;
      end
      if (push) m_q.push_back(k);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic [7:0] key, input logic en, input logic tick, input logic rst);
    mapped_key = key;
    enable     = en;
    game_tick  = tick;
    reset      = rst;
    @(posedge clock);
    model_edge(key, en, tick, rst);
    #1;
    chk("direction", {4'b0000, direction}, {4'b0000, m_dir});
    chk("dir_changed", {7'b0, dir_changed}, {7'b0, m_dc});
    chk("queue_count", {5'b0, queue_count}, 8'(m_q.size()));
    chk("rejected", {7'b0, rejected}, {7'b0, m_rej});
    chk("dropped", {7'b0, dropped}, {7'b0, m_drop});
  endtask

  task automatic hold(input logic [7:0] key, input int n);
    for (int i = 0; i < n; i++) cyc(key, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] rkey;
    int         rlen;
    checks     = 0;
    errors     = 0;
    mapped_key = 8'h00;
    enable     = 1'b0;
    game_tick  = 1'b0;
    reset      = 1'b1;
    model_reset();

    // Reset release, idle ticks.
    cyc(8'h00, 1'b1, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 1'b0, 1'b1);
    chk("reset_dir", {4'b0000, direction}, 8'h08);
    chk("reset_cnt", {5'b0, queue_count}, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cyc(8'h00, 1'b1, 1'b1, 1'b0);
      cyc(8'h00, 1'b1, 1'b0, 1'b0);
    end

    // UP accepted after SS+2 edges, then released by a tick.
    cyc(8'h01, 1'b1, 1'b0, 1'b0);
    cyc(8'h01, 1'b1, 1'b0, 1'b0);
    cyc(8'h01, 1'b1, 1'b0, 1'b0);
    chk("up_not_yet", {5'b0, queue_count}, 8'h00);
    cyc(8'h01, 1'b1, 1'b0, 1'b0);
    chk("up_queued", {5'b0, queue_count}, 8'h01);
    cyc(8'h01, 1'b1, 1'b1, 1'b0);
    chk("up_dir", {4'b0000, direction}, 8'h01);
    hold(8'h01, 2);

    // Rejection against heading, then against queue tail.
    cyc(8'h00, 1'b1, 1'b0, 1'b1);
    hold(8'h00, 3);
    hold(8'hF4, 5);
    hold(8'h02, 5);
    hold(8'h01, 5);
    // Re-press of the same key after a break.
    hold(8'h00, 3);
    hold(8'h01, 5);

    // Full queue drops, then three ticks.
    cyc(8'h00, 1'b1, 1'b0, 1'b1);
    hold(8'h00, 3);
    hold(8'h01, 5);
    hold(8'h04, 5);
    hold(8'h02, 5);
    for (int i = 0; i < 3; i++) begin
      cyc(8'h02, 1'b1, 1'b1, 1'b0);
      cyc(8'h02, 1'b1, 1'b0, 1'b0);
    end
    chk("hold_left", {4'b0000, direction}, 8'h04);

    // Full queue with event and tick on the same edge.
    cyc(8'h00, 1'b1, 1'b0, 1'b1);
    hold(8'h00, 3);
    hold(8'h01, 5);
    hold(8'h04, 5);
    hold(8'h02, 3);
    cyc(8'h02, 1'b1, 1'b1, 1'b0);
    chk("simul_cnt", {5'b0, queue_count}, 8'h02);
    chk("simul_dir", {4'b0000, direction}, 8'h01);

    // Enable low for one cycle clears the queue.
    cyc(8'h02, 1'b0, 1'b0, 1'b0);
    cyc(8'h02, 1'b1, 1'b1, 1'b0);
    hold(8'h02, 2);

    // Reset with turns queued.
    cyc(8'h00, 1'b1, 1'b0, 1'b1);
    hold(8'h00, 3);
    hold(8'h01, 5);
    hold(8'h04, 5);
    cyc(8'h04, 1'b1, 1'b0, 1'b1);
    chk("rst_q_dir", {4'b0000, direction}, 8'h08);
    hold(8'h04, 6);

    // Random phase.
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0:       rkey = 8'h00;
        1:       rkey = 8'($urandom_range(0, 255));
        2, 3:    rkey = {4'($urandom_range(0, 15)), 4'b0001 << $urandom_range(0, 3)};
        default: rkey = {4'b0000, 4'b0001 << $urandom_range(0, 3)};
      endcase
      rlen = $urandom_range(1, 6);
      for (int j = 0; j < rlen; j++) begin
        cyc(rkey, ($urandom_range(0, 19) != 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 299) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
